// File: rtl/apb_demux_pkg.sv
// apb_demux_pkg: shared state encoding and width helpers for the APB demux
package apb_demux_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DERR, TOUT} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction
endpackage

// File: rtl/apb_watchdog_cnt.sv
// apb_watchdog_cnt: wait-cycle counter that flags the cycle on which LIMIT waits are reached
module apb_watchdog_cnt #(
  parameter int LIMIT = 255,
  parameter int W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic exp_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // next count: clear wins over increment
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
  assign exp_o = en_i && cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/apb_demux_timeout.sv
// apb_demux_timeout: APB 1-to-N demux with local decode errors, access watchdog and sticky error capture
module apb_demux_timeout
  import apb_demux_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             m_psel_i,
  input  logic                             m_penable_i,
  input  logic                             m_pwrite_i,
  input  logic [ADDR_WIDTH-1:0]            m_paddr_i,
  input  logic [DATA_WIDTH-1:0]            m_pwdata_i,
  output logic [DATA_WIDTH-1:0]            m_prdata_o,
  output logic                             m_pready_o,
  output logic                             m_pslverr_o,
  output logic [NUM_SLAVES-1:0]            s_psel_o,
  output logic                             s_penable_o,
  output logic                             s_pwrite_o,
  output logic [ADDR_WIDTH-1:0]            s_paddr_o,
  output logic [DATA_WIDTH-1:0]            s_pwdata_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata_i,
  input  logic [NUM_SLAVES-1:0]            s_pready_i,
  input  logic [NUM_SLAVES-1:0]            s_pslverr_i,
  output logic                             err_valid_o,
  output logic                             err_type_o,
  output logic [ADDR_WIDTH-1:0]            err_addr_o,
  input  logic                             err_clr_i
);
  localparam int IDX_W = idx_w(NUM_SLAVES);
  localparam int CNT_W = cnt_w(TIMEOUT_CYCLES);
  localparam logic [IDX_W:0] NS = NUM_SLAVES[IDX_W:0];
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx, sel_q, sel_d;
  logic hit, setup, rdy, slverr, expired, wd_en, err_new;
  logic err_valid_q, err_type_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  assign idx = m_paddr_i[SEL_LSB +: IDX_W];
  assign hit = {1'b0, idx} < NS;
  assign setup = m_psel_i && !m_penable_i;
  assign s_penable_o = m_penable_i;
  assign s_pwrite_o = m_pwrite_i;
  assign s_paddr_o = m_paddr_i;
  assign s_pwdata_o = m_pwdata_i;
  assign wd_en = state_q == ACCESS && m_psel_i && !rdy;
  assign err_new = state_d == DERR || state_d == TOUT;
  assign err_valid_o = err_valid_q;
  assign err_type_o = err_type_q;
  assign err_addr_o = err_addr_q;
  apb_watchdog_cnt #(.LIMIT(TIMEOUT_CYCLES), .W(CNT_W)) u_wd (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (wd_en),
    .clr_i(!wd_en),
    .exp_o(expired)
  );
  // route selects and mux the addressed slave's response; local errors answer on their own
  always_comb begin
    s_psel_o = '0;
    rdy = 1'b0;
    slverr = 1'b0;
    m_prdata_o = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      s_psel_o[k] = (state_q == ACCESS) ? sel_q == k[IDX_W-1:0]
                  : state_q == IDLE && setup && !rst_i && idx == k[IDX_W-1:0];
      if (state_q == ACCESS && sel_q == k[IDX_W-1:0]) begin
        rdy = s_pready_i[k];
        slverr = s_pslverr_i[k];
        m_prdata_o = s_prdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    m_pready_o = (state_q == ACCESS) ? m_psel_i && rdy : state_q == DERR || state_q == TOUT;
    m_pslverr_o = slverr || state_q == DERR || state_q == TOUT;
  end
  // next state: accept SETUP in IDLE, finish or abandon in ACCESS, error states last one cycle
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    case (state_q)
      IDLE: if (setup) begin
        state_d = hit ? ACCESS : DERR;
        sel_d = idx;
      end
      ACCESS: state_d = (!m_psel_i || rdy) ? IDLE : expired ? TOUT : ACCESS;
      default: state_d = IDLE;
    endcase
  end
  // state and target registers
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
    end
  // sticky capture of the first error; a simultaneous clear discards the new one
  always_ff @(posedge clk_i)
    if (rst_i || err_clr_i) begin
      err_valid_q <= 1'b0;
      err_type_q <= 1'b0;
      err_addr_q <= '0;
    end else if (err_new && !err_valid_q) begin
      err_valid_q <= 1'b1;
      err_type_q <= state_d == TOUT;
      err_addr_q <= m_paddr_i;
    end
endmodule
